// File: rtl/bw_seq_multiplier.sv
// Sequential Baugh-Wooley-style multiplier: one partial-product row per clock,
// signed or unsigned operands selected per operation by tc.
module bw_seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 tc,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   p,
    output logic                 busy,
    output logic                 done
);
    localparam int CW = $clog2(WIDTH);
    localparam int PW = 2 * WIDTH;

    typedef enum logic {IDLE, RUN} state_t;

    // Handshake: start is sampled only while busy=0; done is a one-cycle pulse
    // that coincides with p being updated, and busy/done are never high together.
    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              tc_q, tc_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]     p_q, p_d;
    logic              done_q, done_d;

    logic [PW-1:0]     row_x;
    logic [PW-1:0]     row_shift;
    logic              last_row;
    logic [PW-1:0]     acc_next;

    assign row_x     = tc_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    assign row_shift = row_x << cnt_q;
    assign last_row  = (cnt_q == CW'(WIDTH - 1));

    // The multiplier sign bit carries negative weight in two's-complement mode.
    always_comb begin
        acc_next = acc_q;
        if (b_q[cnt_q]) begin
            if (last_row && tc_q) begin
                acc_next = acc_q - row_shift;
            end else begin
                acc_next = acc_q + row_shift;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        tc_d    = tc_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = b;
                    tc_d    = tc;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                acc_d = acc_next;
                cnt_d = cnt_q + CW'(1);
                if (last_row) begin
                    state_d = IDLE;
                    p_d     = acc_next;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            tc_q    <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            tc_q    <= tc_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            done_q  <= done_d;
        end
    end

    assign p    = p_q;
    assign busy = (state_q == RUN);
    assign done = done_q;
endmodule

// File: tb/tb_bw_seq_multiplier.sv
// Directed and swept checks of bw_seq_multiplier at WIDTH=4 and WIDTH=8.
module tb_bw_seq_multiplier;
    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start4 = 1'b0, tc4 = 1'b0;
    logic [3:0]  a4 = '0, b4 = '0;
    logic [7:0]  p4;
    logic        busy4, done4;

    logic        start8 = 1'b0, tc8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] p8;
    logic        busy8, done8;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    bw_seq_multiplier #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .tc(tc4), .a(a4), .b(b4),
        .p(p4), .busy(busy4), .done(done4)
    );

    bw_seq_multiplier #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .tc(tc8), .a(a8), .b(b8),
        .p(p8), .busy(busy8), .done(done8)
    );

    // Driver: lat counts edges after the start edge until done is seen.
    task automatic drive4(input logic tcv, input logic [3:0] av, input logic [3:0] bv,
                          output logic [7:0] pv, output int lat, output logic overlap,
                          output logic done_after);
        @(negedge clk);
        start4 = 1'b1; tc4 = tcv; a4 = av; b4 = bv;
        @(negedge clk);
        start4 = 1'b0;
        lat = 0;
        while (done4 !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        pv = p4;
        overlap = busy4;
        @(negedge clk);
        done_after = done4;
    endtask

    task automatic drive8(input logic tcv, input logic [7:0] av, input logic [7:0] bv,
                          output logic [15:0] pv, output int lat, output logic overlap,
                          output logic done_after);
        @(negedge clk);
        start8 = 1'b1; tc8 = tcv; a8 = av; b8 = bv;
        @(negedge clk);
        start8 = 1'b0;
        lat = 0;
        while (done8 !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        pv = p8;
        overlap = busy8;
        @(negedge clk);
        done_after = done8;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (p4 !== 8'h00)  $display("FAIL reset_p4: got %h expected 00", p4); else passed++;
        total++; if (busy4 !== 1'b0) $display("FAIL reset_busy4: got %b expected 0", busy4); else passed++;
        total++; if (done4 !== 1'b0) $display("FAIL reset_done4: got %b expected 0", done4); else passed++;
        total++; if (p8 !== 16'h0000) $display("FAIL reset_p8: got %h expected 0000", p8); else passed++;
        total++; if (busy8 !== 1'b0) $display("FAIL reset_busy8: got %b expected 0", busy8); else passed++;
        total++; if (done8 !== 1'b0) $display("FAIL reset_done8: got %b expected 0", done8); else passed++;
        rst = 1'b0;
    endtask

    task automatic test_w4_vectors();
        logic       tv [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [3:0] av [8] = '{4'b0001, 4'b1101, 4'b1010, 4'b0111, 4'b1111, 4'b1000, 4'b1000, 4'b1111};
        logic [3:0] bv [8] = '{4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b1111, 4'b1000, 4'b0111, 4'b1111};
        logic [7:0] ev [8] = '{8'h03, 8'hFA, 8'h24, 8'h2A, 8'h01, 8'h40, 8'hC8, 8'hE1};
        logic [7:0] pv;
        int         lat;
        logic       ov, da;
        for (int i = 0; i < 8; i++) begin
            drive4(tv[i], av[i], bv[i], pv, lat, ov, da);
            total++; if (pv !== ev[i]) $display("FAIL w4_product[%0d]: got %h expected %h", i, pv, ev[i]); else passed++;
            total++; if (lat != 4) $display("FAIL w4_latency[%0d]: got %0d expected 4", i, lat); else passed++;
            total++; if (ov !== 1'b0) $display("FAIL w4_busy_with_done[%0d]: got %b expected 0", i, ov); else passed++;
            total++; if (da !== 1'b0) $display("FAIL w4_done_pulse[%0d]: got %b expected 0", i, da); else passed++;
        end
    endtask

    task automatic test_w8_extremes();
        logic        tv [3] = '{1'b1, 1'b1, 1'b0};
        logic [7:0]  av [3] = '{8'h80, 8'h7F, 8'hFF};
        logic [7:0]  bv [3] = '{8'h80, 8'h80, 8'hFF};
        logic [15:0] ev [3] = '{16'h4000, 16'hC080, 16'hFE01};
        logic [15:0] pv;
        int          lat;
        logic        ov, da;
        for (int i = 0; i < 3; i++) begin
            drive8(tv[i], av[i], bv[i], pv, lat, ov, da);
            total++; if (pv !== ev[i]) $display("FAIL w8_extreme[%0d]: got %h expected %h", i, pv, ev[i]); else passed++;
            total++; if (lat != 8) $display("FAIL w8_latency[%0d]: got %0d expected 8", i, lat); else passed++;
            total++; if (da !== 1'b0) $display("FAIL w8_done_pulse[%0d]: got %b expected 0", i, da); else passed++;
        end
    endtask

    task automatic test_random_sweep();
        logic [15:0] pv, ev;
        logic [7:0]  av, bv;
        int          lat, sa, sb, nbad;
        logic        ov, da;
        for (int m = 0; m < 2; m++) begin
            nbad = 0;
            for (int i = 0; i < 1000; i++) begin
                av = 8'($urandom_range(0, 255));
                bv = 8'($urandom_range(0, 255));
                if (m == 1) begin
                    sa = $signed(av);
                    sb = $signed(bv);
                end else begin
                    sa = int'(av);
                    sb = int'(bv);
                end
                ev = 16'(sa * sb);
                drive8(m[0], av, bv, pv, lat, ov, da);
                if (pv !== ev || lat != 8) begin
                    nbad++;
                    if (nbad <= 5)
                        $display("FAIL sweep_tc%0d: a=%h b=%h got %h lat %0d expected %h lat 8", m, av, bv, pv, lat, ev);
                end
            end
            total++; if (nbad != 0) $display("FAIL sweep_tc%0d_errors: got %0d expected 0", m, nbad); else passed++;
        end
    endtask

    task automatic test_start_while_busy();
        logic [15:0] prev, first_p;
        int          ndone;
        prev = p8;
        @(negedge clk);
        start8 = 1'b1; tc8 = 1'b1; a8 = 8'h05; b8 = 8'hFD;
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        start8 = 1'b1; tc8 = 1'b0; a8 = 8'h10; b8 = 8'h10;
        total++; if (busy8 !== 1'b1) $display("FAIL midstart_busy: got %b expected 1", busy8); else passed++;
        total++; if (p8 !== prev) $display("FAIL midstart_p_stable: got %h expected %h", p8, prev); else passed++;
        @(negedge clk);
        start8 = 1'b0;
        ndone = 0;
        first_p = '0;
        for (int i = 0; i < 20; i++) begin
            if (done8 === 1'b1) begin
                if (ndone == 0) first_p = p8;
                ndone++;
            end
            @(negedge clk);
        end
        total++; if (ndone != 1) $display("FAIL midstart_done_count: got %0d expected 1", ndone); else passed++;
        total++; if (first_p !== 16'hFFF1) $display("FAIL midstart_product: got %h expected fff1", first_p); else passed++;
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        start8 = 1'b1; tc8 = 1'b0; a8 = 8'h0C; b8 = 8'h0A;
        @(negedge clk);
        start8 = 1'b0;
        lat = 0;
        while (done8 !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        total++; if (p8 !== 16'h0078) $display("FAIL b2b_first: got %h expected 0078", p8); else passed++;
        start8 = 1'b1; tc8 = 1'b1; a8 = 8'hFE; b8 = 8'h03;
        @(negedge clk);
        start8 = 1'b0;
        lat = 0;
        while (done8 !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        total++; if (lat != 8) $display("FAIL b2b_latency: got %0d expected 8", lat); else passed++;
        total++; if (p8 !== 16'hFFFA) $display("FAIL b2b_second: got %h expected fffa", p8); else passed++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        logic [15:0] pv;
        int          lat, ndone;
        logic        ov, da;
        @(negedge clk);
        start8 = 1'b1; tc8 = 1'b0; a8 = 8'h7F; b8 = 8'h7F;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1; start8 = 1'b1;
        @(negedge clk);
        total++; if (p8 !== 16'h0000) $display("FAIL rstmid_p: got %h expected 0000", p8); else passed++;
        total++; if (busy8 !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", busy8); else passed++;
        total++; if (done8 !== 1'b0) $display("FAIL rstmid_done: got %b expected 0", done8); else passed++;
        rst = 1'b0; start8 = 1'b0;
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done8 === 1'b1) ndone++;
        end
        total++; if (ndone != 0) $display("FAIL rstmid_no_done: got %0d expected 0", ndone); else passed++;
        total++; if (busy8 !== 1'b0) $display("FAIL rstmid_start_ignored: got busy %b expected 0", busy8); else passed++;
        drive8(1'b0, 8'h12, 8'h34, pv, lat, ov, da);
        total++; if (pv !== 16'h03A8) $display("FAIL rstmid_after: got %h expected 03a8", pv); else passed++;
    endtask

    task automatic test_operand_hold();
        int lat;
        @(negedge clk);
        start8 = 1'b1; tc8 = 1'b1; a8 = 8'h9C; b8 = 8'h33;
        @(negedge clk);
        start8 = 1'b0;
        lat = 0;
        while (done8 !== 1'b1 && lat < 40) begin
            a8  = 8'($urandom_range(0, 255));
            b8  = 8'($urandom_range(0, 255));
            tc8 = ~tc8;
            @(negedge clk);
            lat++;
        end
        total++; if (lat != 8) $display("FAIL hold_latency: got %0d expected 8", lat); else passed++;
        total++; if (p8 !== 16'hEC14) $display("FAIL hold_product: got %h expected ec14", p8); else passed++;
    endtask

    initial begin
        test_reset();
        test_w4_vectors();
        test_w8_extremes();
        test_random_sweep();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_run();
        test_operand_hold();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/bw_seq_multiplier.md
# bw_seq_multiplier

Parametrised, sequential Baugh-Wooley-style multiplier for the FIR/IIR filter datapath. It replaces the fixed 4-bit combinational signed multiplier with a width-generic, one-partial-product-per-cycle engine. A mode bit selects two's-complement or unsigned operands per operation. A start/busy/done handshake lets a filter controller time-share one multiplier across taps.

## Interface
- WIDTH, 8, operand width in bits (≥2); product is 2*WIDTH bits
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request a multiplication; sampled only when busy=0
- tc  input  1  1 = both operands two's complement, 0 = both unsigned; latched with start
- a  input  WIDTH  multiplicand; latched with start
- b  input  WIDTH  multiplier; latched with start
- p  output  2*WIDTH  registered product; holds until the next completion
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse marking that p has just been updated

## Operation
- States:
  - IDLE: busy=0.
  - RUN: busy=1. Row counter i runs 0..WIDTH-1.
- IDLE→RUN when start=1 at an edge. That edge performs these updates:
  - Latch a, b and tc.
  - Clear the 2*WIDTH accumulator.
  - Set i=0 and busy<=1.
- Each RUN edge processes row i:
  - Form the row operand x from a (extended to 2*WIDTH bits):
    - tc=1: sign-extend a.
    - tc=0: zero-extend a.
  - If b[i]=1, update the accumulator:
    - For i<WIDTH-1, or when tc=0: acc += x<<i.
    - For i=WIDTH-1 with tc=1: acc −= x<<i. This is the negative weight of the multiplier sign bit (Baugh-Wooley correction).
  - Then increment i.
  - All arithmetic is modulo 2^(2*WIDTH). The result is exact for every operand pair in both modes, because no product overflows 2*WIDTH bits.
- RUN→IDLE on the edge that processes row WIDTH-1. That edge performs these updates:
  - p <= final accumulator.
  - done <= 1.
  - busy <= 0.
- done deasserts on the next edge unconditionally.
- start while busy=1: ignored. No queuing, and no effect on latched operands.
- start in the cycle where done=1: accepted, because busy=0 by then. Back-to-back throughput is one product per WIDTH cycles.
- Changes to a, b or tc after the start edge have no effect on the operation in flight.
- Reset, including mid-operation:
  - state=IDLE.
  - p=0, busy=0, done=0.
  - Accumulator, counter and latched operands are cleared.
  - An in-flight operation is discarded and produces no done.
  - start asserted in the same cycle as rst is ignored.

## Timing
- Reset values: p=0, busy=0, done=0.
- Latency: start sampled at edge E0. Rows are processed at edges E1..EWIDTH. p is valid and done=1 in the cycle following edge EWIDTH, i.e. WIDTH cycles after the start edge.
- busy is high from after E0 through the cycle before done. busy and done are never high together.
- p changes only at completion edges and at reset. It is stable at all other times, including during RUN.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- WIDTH=4, tc=1, (a,b) = (0001,0011), (1101,0010), (1010,1010), (0111,0110), (1111,1111) → p = 0x03, 0xFA, 0x24, 0x2A, 0x01. Each done arrives exactly 4 cycles after its start, as one pulse.
- WIDTH=4 extremes:
  - tc=1: −8×−8 → 0x40; −8×7 → 0xC8.
  - tc=0: a=b=1111 → 0xE1 (15×15=225).
- WIDTH=8:
  - tc=1: 0x80×0x80 → 0x4000; 0x7F×0x80 → 0xC080.
  - tc=0: 0xFF×0xFF → 0xFE01.
  - Random sweep of ≥1000 pairs in each mode, checked against a behavioural `*` model.
- Handshake, WIDTH=8:
  - Pulse start again 3 cycles into a run, with different operands → the first result is unaffected, and exactly one done pulse occurs.
  - Assert start in the done cycle → the second result appears 8 cycles later.
- Reset mid-operation: assert rst at cycle 5 of an 8-cycle run → p=0, busy=0, and no done pulse. A subsequent start yields the correct product.
- Operand hold: toggle a, b and tc every cycle during RUN → p equals the product of the values latched at start.
